// File: rtl/mdu_if.sv
// Pipeline-to-mul/div-unit bus: op issue, forwarded operands, HI/LO and status back.
interface mdu_if #(parameter int WIDTH = 32);
  logic             start;
  logic [3:0]       op;
  logic             cancel;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             busy;
  logic             stall_req;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] md_out;

  modport master (output start, op, cancel, rs_val, rt_val,
                  input  busy, stall_req, hi, lo, md_out);
  modport slave  (input  start, op, cancel, rs_val, rt_val,
                  output busy, stall_req, hi, lo, md_out);
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle MIPS multiply/divide unit with architectural HI/LO.
// Define MDU_MADD_EN to add madd/maddu/msub/msubu (ops 1000-1011).
module mul_div_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic  clk,
  input  logic  reset,
  mdu_if.slave  bus
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES - 1);

  logic             busy_q;
  logic [CW-1:0]    cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
  logic             is_long, accept;

`ifdef MDU_MADD_EN
  assign is_long = (bus.op[3:2] == 2'b00) | (bus.op[3:2] == 2'b10);
`else
  assign is_long = (bus.op[3:2] == 2'b00);
`endif
  assign accept = bus.start & ~bus.cancel & ~busy_q;

  // Products on zero/sign-extended operands keep everything unsigned at 2*WIDTH.
  logic [2*WIDTH-1:0] prod_s, prod_u, prod;
  assign prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
  assign prod   = op_q[0] ? prod_u : prod_s;

  // Signed divide via magnitudes so MIN/-1 wraps to MIN instead of overflowing.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b, quo_m, rem_m, quo, rem;
  assign a_neg = ~op_q[0] & a_q[WIDTH-1];
  assign b_neg = ~op_q[0] & b_q[WIDTH-1];
  assign abs_a = a_neg ? -a_q : a_q;
  assign abs_b = b_neg ? -b_q : b_q;
  assign quo_m = abs_a / abs_b;
  assign rem_m = abs_a % abs_b;
  assign quo   = (a_neg ^ b_neg) ? -quo_m : quo_m;
  assign rem   = a_neg ? -rem_m : rem_m;

  logic               res_wr;
  logic [2*WIDTH-1:0] res;
  always_comb begin
    res_wr = 1'b1;
    res    = prod;
    if (op_q[1] & ~op_q[3]) begin
      res_wr = |b_q;
      res    = {rem, quo};
    end
`ifdef MDU_MADD_EN
    if (op_q[3])
      res = op_q[1] ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else if (busy_q) begin
      if (cnt == '0) begin
        busy_q <= 1'b0;
        if (res_wr) {hi_q, lo_q} <= res;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end else if (accept) begin
      if (is_long) begin
        a_q    <= bus.rs_val;
        b_q    <= bus.rt_val;
        op_q   <= bus.op;
        busy_q <= 1'b1;
        cnt    <= (bus.op[1] & ~bus.op[3]) ? DIV_LD : MULT_LD;
      end else if (bus.op == 4'b0100) begin
        hi_q <= bus.rs_val;
      end else if (bus.op == 4'b0101) begin
        lo_q <= bus.rs_val;
      end
    end
  end

  always_comb begin
    case (bus.op)
      4'b0110: bus.md_out = hi_q;
      4'b0111: bus.md_out = lo_q;
      default: bus.md_out = '0;
    endcase
  end

  assign bus.busy      = busy_q;
  assign bus.stall_req = busy_q | (bus.start & is_long & ~bus.cancel);
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: arithmetic reference model plus literal checks.
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  mdu_if #(.WIDTH(32)) bus ();
  mul_div_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic bit long_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op <= 4'd3) || (op >= 4'd8 && op <= 4'd11);
`else
    return op <= 4'd3;
`endif
  endfunction

  // Returns {write, hi, lo} for a completed long op, using plain 64-bit arithmetic.
  function automatic logic [64:0] model_res(input logic [3:0] op,
      input logic [31:0] a, input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
    longint      sa, sb;
    logic [63:0] acc, ps, pu;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    acc = {hi, lo};
    ps  = 64'(sa * sb);
    pu  = {32'b0, a} * {32'b0, b};
    case (op)
      4'd0: return {1'b1, ps};
      4'd1: return {1'b1, pu};
      4'd2: return (b == 0) ? {1'b0, acc} : {1'b1, 32'(sa % sb), 32'(sa / sb)};
      4'd3: return (b == 0) ? {1'b0, acc} : {1'b1, a % b, a / b};
      4'd8: return {1'b1, acc + ps};
      4'd9: return {1'b1, acc + pu};
      4'd10: return {1'b1, acc - ps};
      4'd11: return {1'b1, acc - pu};
      default: return {1'b0, acc};
    endcase
  endfunction

  // Reference model: remaining busy cycles plus the pending op.
  logic [31:0] m_hi, m_lo, m_a, m_b;
  logic [3:0]  m_op;
  int          m_rem;
  logic [64:0] m_r;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi <= 0; m_lo <= 0; m_rem <= 0; m_op <= 0; m_a <= 0; m_b <= 0;
    end else if (m_rem > 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_r = model_res(m_op, m_a, m_b, m_hi, m_lo);
        if (m_r[64]) begin
          m_hi <= m_r[63:32];
          m_lo <= m_r[31:0];
        end
      end
    end else if (bus.start && !bus.cancel) begin
      if (long_op(bus.op)) begin
        m_op  <= bus.op;
        m_a   <= bus.rs_val;
        m_b   <= bus.rt_val;
        m_rem <= (bus.op == 4'd2 || bus.op == 4'd3) ? 10 : 5;
      end else if (bus.op == 4'd4) m_hi <= bus.rs_val;
      else if (bus.op == 4'd5) m_lo <= bus.rs_val;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("busy", 64'(bus.busy), 64'(m_rem > 0));
      chk("stall_req", 64'(bus.stall_req),
          64'((m_rem > 0) || (bus.start && !bus.cancel && long_op(bus.op))));
      chk("hi", 64'(bus.hi), 64'(m_hi));
      chk("lo", 64'(bus.lo), 64'(m_lo));
      chk("md_out", 64'(bus.md_out),
          64'((bus.op == 4'd6) ? m_hi : (bus.op == 4'd7) ? m_lo : 32'd0));
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_in(input logic st, input logic [3:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic cn);
    bus.start = st; bus.op = op; bus.rs_val = rs; bus.rt_val = rt; bus.cancel = cn;
  endtask

  // Counts busy cycles remaining from the current cycle, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 200) begin n++; step(1); end
    if (n >= 200) chk("idle_timeout", 64'(n), 64'd0);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    set_in(1'b1, op, rs, rt, 1'b0);
    step(1);
    set_in(1'b0, 4'hF, 32'd0, 32'd0, 1'b0);
  endtask

  int n;

  initial begin
    reset = 1'b1;
    set_in(1'b0, 4'hF, 32'd0, 32'd0, 1'b0);
    step(2);
    reset = 1'b0;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);

    // Reset during busy cycle 2 aborts the multiply
    issue(4'd0, 32'd7, 32'd6);
    step(1);
    reset = 1'b1;
    #1;
    chk("rstmid_busy", 64'(bus.busy), 64'd0);
    chk("rstmid_lo", 64'(bus.lo), 64'd0);
    step(1);
    reset = 1'b0;
    step(8);
    chk("rstmid_nowrite_hi", 64'(bus.hi), 64'd0);
    chk("rstmid_nowrite_lo", 64'(bus.lo), 64'd0);

    issue(4'd0, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    chk("mult_cycles", 64'(n), 64'd5);
    chk("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(bus.lo), 64'hFFFF_FFFA);

    issue(4'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    chk("div_cycles", 64'(n), 64'd10);
    chk("div_lo", 64'(bus.lo), 64'hFFFF_FFFD);
    chk("div_hi", 64'(bus.hi), 64'hFFFF_FFFF);

    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    chk("divu_lo", 64'(bus.lo), 64'h7FFF_FFFC);
    chk("divu_hi", 64'(bus.hi), 64'd1);

    issue(4'd4, 32'h11, 32'd0);
    issue(4'd5, 32'h22, 32'd0);
    issue(4'd2, 32'd5, 32'd0);
    wait_idle(n);
    chk("div0_cycles", 64'(n), 64'd10);
    chk("div0_hi", 64'(bus.hi), 64'h11);
    chk("div0_lo", 64'(bus.lo), 64'h22);

    issue(4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("divmin_lo", 64'(bus.lo), 64'h8000_0000);
    chk("divmin_hi", 64'(bus.hi), 64'd0);

    issue(4'd4, 32'hABCD, 32'd0);
    chk("mthi_hi", 64'(bus.hi), 64'hABCD);
    chk("mthi_busy", 64'(bus.busy), 64'd0);

    // mflo held while a multu is in flight
    issue(4'd1, 32'd3, 32'd4);
    set_in(1'b1, 4'd7, 32'd0, 32'd0, 1'b0);
    n = 0;
    while (bus.stall_req && n < 200) begin n++; step(1); end
    chk("mflo_stall_cycles", 64'(n), 64'd5);
    chk("mflo_md_out", 64'(bus.md_out), 64'd12);
    set_in(1'b0, 4'hF, 32'd0, 32'd0, 1'b0);

    // Starts and mthi while busy are dropped
    set_in(1'b1, 4'd0, 32'd2, 32'd2, 1'b0);
    step(1);
    set_in(1'b1, 4'd0, 32'd5, 32'd5, 1'b0);
    step(2);
    set_in(1'b1, 4'd4, 32'h99, 32'd0, 1'b0);
    step(1);
    set_in(1'b0, 4'hF, 32'd0, 32'd0, 1'b0);
    wait_idle(n);
    chk("b2b_lo", 64'(bus.lo), 64'd4);
    chk("b2b_hi", 64'(bus.hi), 64'd0);

    set_in(1'b1, 4'd0, 32'd9, 32'd9, 1'b1);
    step(1);
    chk("cancel_busy", 64'(bus.busy), 64'd0);
    set_in(1'b0, 4'hF, 32'd0, 32'd0, 1'b0);
    step(6);
    chk("cancel_lo", 64'(bus.lo), 64'd4);

    issue(4'hC, 32'h55, 32'h66);
    issue(4'h8, 32'h55, 32'h66);
    step(6);

`ifdef MDU_MADD_EN
    issue(4'd4, 32'd0, 32'd0);
    issue(4'd5, 32'd5, 32'd0);
    issue(4'd8, 32'd2, 32'd3);
    wait_idle(n);
    chk("madd_cycles", 64'(n), 64'd5);
    chk("madd_lo", 64'(bus.lo), 64'd11);
    chk("madd_hi", 64'(bus.hi), 64'd0);
`else
    chk("noop_lo", 64'(bus.lo), 64'd4);
    chk("noop_busy", 64'(bus.busy), 64'd0);
`endif

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers, sitting in the EX stage of the five-stage MIPS pipeline.
- Successor to the current combinational HI/LO read path: parametrised width and latencies, a start/busy handshake, mthi/mtlo writes, and exception cancel.
- Hazard logic stalls the pipeline on stall_req.
- md_out feeds the E-stage result path for mfhi/mflo.

Parameters:
- WIDTH, 32: operand and HI/LO width.
- MULT_CYCLES, 5: busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10: busy cycles for div/divu (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  E-stage instruction is a mul/div-unit op this cycle.
- op  input  4  0000 mult, 0001 multu, 0010 div, 0011 divu, 0100 mthi, 0101 mtlo, 0110 mfhi, 0111 mflo; others are no-op.
- cancel  input  1  exception/flush in flight; suppresses start this cycle.
- rs_val  input  WIDTH  forwarded rs operand (MFRSE).
- rt_val  input  WIDTH  forwarded rt operand (MFRTE).
- busy  output  1  operation in progress.
- stall_req  output  1  busy | (start & op in 0000..0011 & ~cancel), combinational.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- md_out  output  WIDTH  combinational: op==0110 gives hi, op==0111 gives lo, else 0.

Behaviour:
- Reset: busy=0, hi=0, lo=0, counter=0, latched operands=0. Asserting reset mid-operation aborts the operation; no HI/LO update follows.
- Accept condition: start & ~cancel & ~busy.
- Accept of op 00xx: latch rs_val, rt_val and op on that edge; busy=1 from the next cycle.
- Counter loads MULT_CYCLES-1 or DIV_CYCLES-1 and decrements each cycle.
- On the edge where the counter is 0 and busy=1: write HI/LO and clear busy.
- busy is high exactly MULT_CYCLES or DIV_CYCLES cycles. New HI/LO are visible the first cycle busy=0.
- start while busy: ignored. Upstream is stalled by stall_req and re-presents the op.
- mult: {hi,lo} = signed rs × signed rt, full 2·WIDTH product. multu: unsigned.
- div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
- divu: unsigned div.
- Divide by zero: full DIV_CYCLES busy period, then hi and lo are unchanged.
- div of most-negative value by -1: lo=most-negative, hi=0.
- mthi/mtlo (accepted, not busy): hi or lo = rs_val on the next edge; single cycle; busy stays 0.
- mthi/mtlo while busy: ignored; stall_req is already high.
- mfhi/mflo: no state change; md_out returns current hi/lo. While busy, stall_req holds the pipeline.
- cancel=1 with start: no latch, no HI/LO write, busy unchanged. cancel has no effect on an operation already running.
- Undefined op codes with start: no effect.

Optional Feature:
- Macro MDU_MADD_EN. When defined, four extra ops are accepted:
  - 1000 madd: {hi,lo} += signed product.
  - 1001 maddu: unsigned accumulate.
  - 1010 msub: {hi,lo} -= signed product.
  - 1011 msubu: unsigned subtract.
- These ops use MULT_CYCLES latency and read HI/LO at completion. 2·WIDTH wrap-around on overflow.
- stall_req covers these ops.
- When not defined: 1000-1011 are no-ops and stall_req ignores them.

Test Plan:
- Reset mid-op: mult 7×6, reset on busy cycle 2 → busy=0, hi=0, lo=0 the same cycle; no later write.
- mult signed (defaults): rs=0xFFFFFFFE (-2), rt=3 → busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- Signed vs unsigned divide:
  - div rs=-7, rt=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu rs=0xFFFFFFF9, rt=2 → lo=0x7FFFFFFC, hi=1.
- Divide edge cases:
  - div by zero with hi=0x11, lo=0x22 preset → unchanged after 10 busy cycles.
  - div 0x80000000 by 0xFFFFFFFF → lo=0x80000000, hi=0.
- Handshake:
  - mthi rs=0xABCD → hi=0xABCD next cycle, busy=0.
  - mflo during busy → stall_req=1 until busy falls, then md_out=new lo.
  - Back-to-back start while busy → ignored.
- cancel/feature:
  - start mult with cancel=1 → busy stays 0, hi/lo unchanged.
  - With MDU_MADD_EN: hi=0, lo=5, then madd 2×3 → lo=11.
